// File: rtl/clk_switch_seq.sv
// clk_switch_seq: glitch-safe clock reconfiguration sequencer.
// Applies a requested clock configuration in this order: park on HSI,
// enable the PLL and wait for lock (when needed), change the
// source/divider selects, then release to the target source.
// In IDLE it watches the PLL lock and falls back to HSI if lock is lost.
// Optional macro CLKSEQ_LOCK_TIMEOUT_EN: builds the PLL lock timeout
// counter and the PLL_WAIT abort path. Without it, PLL_WAIT waits for lock
// indefinitely.

package clk_switch_seq_pkg;

  localparam int unsigned CFG_W = 6;
  localparam int unsigned CNT_W = 16;

  // Mux/divider select payload, same bit layout as req_cfg/cfg_out
  typedef struct packed {
    logic       hsisel;
    logic       divbypass;
    logic       pllbypass;
    logic       pllsrc;
    logic [1:0] plldiv;
  } clk_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PARK     = 3'd1,
    ST_PLL_WAIT = 3'd2,
    ST_CFG      = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

endpackage

module clk_switch_seq
  import clk_switch_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1024
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CFG_W-1:0] req_cfg,
  input  logic             pll_lock,
  output logic [CFG_W-1:0] cfg_out,
  output logic             pll_ena,
  output logic             busy,
  output logic             done,
  output logic             lock_err
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Reject out-of-range parameters at elaboration
  if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 65535 ||
      LOCK_TIMEOUT == 0 || LOCK_TIMEOUT > 65535) begin : g_param_check
    $error("clk_switch_seq: SETTLE_CYCLES/LOCK_TIMEOUT out of range 1..65535");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  clk_cfg_t         tgt_q, tgt_d;
  logic             pll_needed_q, pll_needed_d;
  clk_cfg_t         cfg_q, cfg_d;
  logic             pll_ena_q, pll_ena_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lock_err_q, lock_err_d;
  logic             req_ready_q, req_ready_d;

  logic             lock_meta_q, lock_sync_q, lock_prev_q;
  logic             lock_fall;
  logic             accept;

`ifdef CLKSEQ_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
`endif

  assign req_ready = req_ready_q;
  assign cfg_out   = cfg_q;
  assign pll_ena   = pll_ena_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lock_err  = lock_err_q;

  assign accept    = req_valid & req_ready_q;
  assign lock_fall = lock_prev_q & ~lock_sync_q;

  // Two-flop synchronizer for the async PLL lock, plus a delayed copy for edge detect
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      lock_prev_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
      lock_prev_q <= lock_sync_q;
    end
  end

`ifdef CLKSEQ_LOCK_TIMEOUT_EN
  // Lock wait timer: zero on PLL_WAIT entry, counts every cycle spent there
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_PLL_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`endif

  // State and registered-output flops
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tgt_q        <= '0;
      pll_needed_q <= 1'b0;
      cfg_q        <= '0;
      pll_ena_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lock_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      pll_needed_q <= pll_needed_d;
      cfg_q        <= cfg_d;
      pll_ena_q    <= pll_ena_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lock_err_q   <= lock_err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    tgt_d        = tgt_q;
    pll_needed_d = pll_needed_q;
    cfg_d        = cfg_q;
    pll_ena_d    = pll_ena_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lock_err_d   = lock_err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          tgt_d        = clk_cfg_t'(req_cfg);
          pll_needed_d = req_cfg[5] & req_cfg[3];
          lock_err_d   = 1'b0;
          cfg_d.hsisel = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_PARK;
        end else if (pll_ena_q && cfg_q.hsisel && cfg_q.pllbypass && lock_fall) begin
          // Running from the PLL and lock dropped: fall back to HSI
          cfg_d.hsisel = 1'b0;
          lock_err_d   = 1'b1;
        end
      end

      ST_PARK: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (pll_needed_q) begin
            pll_ena_d = 1'b1;
            state_d   = ST_PLL_WAIT;
          end else begin
            pll_ena_d = 1'b0;
            cfg_d     = clk_cfg_t'({cfg_q.hsisel, tgt_q[CFG_W-2:0]});
            state_d   = ST_CFG;
          end
        end
      end

      ST_PLL_WAIT: begin
        cnt_d = '0;
        if (lock_sync_q) begin
          cfg_d   = clk_cfg_t'({cfg_q.hsisel, tgt_q[CFG_W-2:0]});
          state_d = ST_CFG;
        end
`ifdef CLKSEQ_LOCK_TIMEOUT_EN
        else if (tmo_cnt_q == LOCK_LAST) begin
          // PLL never locked: stay parked on HSI and report
          lock_err_d = 1'b1;
          pll_ena_d  = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
`endif
      end

      ST_CFG: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d        = '0;
          cfg_d.hsisel = tgt_q.hsisel;
          state_d      = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

endmodule
